// File: rtl/adder4_bist_pkg.sv
// Shared definitions for the adder self-test engine: state encodings and
// the default operand width.
package adder4_bist_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/adder4_bist_if.sv
// Operand/result bus between the self-test engine and the adder under test.
// The engine is the master (drives operands, receives the sum); the adder
// is the slave.
interface adder4_bist_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic [WIDTH-1:0] dut_s;
  logic             dut_cout;

  modport master (
    output dut_a,
    output dut_b,
    input  dut_s,
    input  dut_cout
  );

  modport slave (
    input  dut_a,
    input  dut_b,
    output dut_s,
    output dut_cout
  );
endinterface

// File: rtl/adder4_bist_vecgen.sv
// Vector index and settle counter for the exhaustive operand sweep.
// advance marks the sampling cycle of the current vector; last flags the
// final vector of the sweep.
module adder4_bist_vecgen
  import adder4_bist_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               en,
  output logic               advance,
  output logic               last,
  output logic [2*WIDTH-1:0] idx
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [2*WIDTH-1:0] r_idx;
  logic [3:0]         r_cnt;

  // Hold each vector SETTLE+1 cycles, then step to the next one; the index
  // parks on all-ones after the final compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == SETTLE_C) begin
        r_cnt <= '0;
        if (!last) r_idx <= r_idx + (2*WIDTH)'(1);
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign last    = &r_idx;
  assign advance = en && (r_cnt == SETTLE_C);
  assign idx     = r_idx;

endmodule

// File: rtl/adder4_bist.sv
// Self-test engine for the ripple adder: sweeps every {A,B} pair, checks
// {cout,S} against a golden sum and keeps pass/fail, an error count and
// the first failing vector for the board to display.
module adder4_bist
  import adder4_bist_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  adder4_bist_if.master        bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic                 fail_valid,
  output logic [2*WIDTH-1:0]   first_fail
);

  localparam int ERR_W = 2*WIDTH + 1;

  state_t             r_state, w_state_nxt;
  logic               w_run, w_start, w_advance, w_last, w_mis;
  logic [2*WIDTH-1:0] w_idx;
  logic [WIDTH:0]     w_gold;
  logic [ERR_W-1:0]   w_err_nxt;

  logic               r_busy, r_done, r_pass, r_fv;
  logic [ERR_W-1:0]   r_err;
  logic [2*WIDTH-1:0] r_ff;

  assign w_run   = (r_state == RUN);
  assign w_start = start && !w_run;

  adder4_bist_vecgen #(
    .WIDTH  (WIDTH),
    .SETTLE (SETTLE)
  ) u_vecgen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_start),
    .en      (w_run),
    .advance (w_advance),
    .last    (w_last),
    .idx     (w_idx)
  );

  // Operands come straight from the registered index, so they only move on
  // vector advance or sweep start.
  assign bus.dut_a = w_idx[2*WIDTH-1:WIDTH];
  assign bus.dut_b = w_idx[WIDTH-1:0];

  assign w_gold    = {1'b0, bus.dut_a} + {1'b0, bus.dut_b};
  assign w_mis     = w_advance && ({bus.dut_cout, bus.dut_s} != w_gold);
  assign w_err_nxt = r_err + (w_mis ? ERR_W'(1) : ERR_W'(0));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: start is honoured only outside RUN; the sweep ends after
  // the last vector has been compared.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: if (start) w_state_nxt = RUN;
      RUN:        if (w_advance && w_last) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Status and result registers; pass folds in the final compare so it is
  // valid on the same cycle done pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_fv   <= 1'b0;
      r_err  <= '0;
      r_ff   <= '0;
    end else begin
      r_busy <= (w_state_nxt == RUN);
      r_done <= w_run && (w_state_nxt == DONE);
      if (w_start) begin
        r_pass <= 1'b0;
        r_fv   <= 1'b0;
        r_err  <= '0;
        r_ff   <= '0;
      end else if (w_advance) begin
        r_err <= w_err_nxt;
        if (w_mis && !r_fv) begin
          r_fv <= 1'b1;
          r_ff <= w_idx;
        end
        if (w_last) r_pass <= (w_err_nxt == '0);
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fv;
  assign first_fail = r_ff;

endmodule

// File: tb/tb_adder4_bist.sv
// Bench for adder4_bist: a behavioural adder with selectable stuck-at
// faults sits on the slave side of the bus; directed sweeps check latency,
// results, restart-ignore, mid-sweep reset and result clearing.
module tb_adder4_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, pass, fail_valid;
  logic [8:0] err_count;
  logic [7:0] first_fail;
  int         fault;
  int         n_total = 0;
  int         n_bad   = 0;
  int         dc;

  adder4_bist_if #(.WIDTH(4)) bus ();

  adder4_bist #(.WIDTH(4), .SETTLE(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;

  // Adder under test: 0 = correct, 1 = S[0] stuck at 0, 2 = cout stuck at 0.
  logic [4:0] sum;
  always_comb begin
    sum = {1'b0, bus.dut_a} + {1'b0, bus.dut_b};
    if (fault == 1) sum[0] = 1'b0;
    if (fault == 2) sum[4] = 1'b0;
    bus.dut_s    = sum[3:0];
    bus.dut_cout = sum[4];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pulse start, then follow the sweep cycle by cycle. Cycle 1 is the cycle
  // after the start edge. restart_at pulses start again; abort_at drops
  // rst_n for one edge and returns.
  task automatic run_sweep(input int restart_at, input int abort_at, output int done_cyc);
    int         cyc;
    int         vbad;
    logic [7:0] exp_idx;
    done_cyc = -1;
    vbad     = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    chk("busy_rise", 32'(busy), 32'd1);
    chk("clr_on_start", 32'({fail_valid, first_fail, err_count, pass}), 32'd0);
    while (cyc <= 600) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc <= 512) begin
        exp_idx = 8'((cyc - 1) / 2);
        if ({bus.dut_a, bus.dut_b} !== exp_idx) vbad++;
      end
      start = (cyc == restart_at);
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("vec_seq", 32'(vbad), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fault = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_results", 32'({pass, fail_valid, err_count, first_fail}), 32'd0);
    chk("rst_ab", 32'({bus.dut_a, bus.dut_b}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct adder.
    run_sweep(0, 0, dc);
    chk("good_done_cyc", 32'(dc), 32'd513);
    chk("good_pass", 32'(pass), 32'd1);
    chk("good_err", 32'(err_count), 32'd0);
    chk("good_fv", 32'(fail_valid), 32'd0);
    chk("good_ff", 32'(first_fail), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // S[0] stuck at 0: every odd sum fails.
    fault = 1;
    run_sweep(0, 0, dc);
    chk("s0_done_cyc", 32'(dc), 32'd513);
    chk("s0_err", 32'(err_count), 32'd128);
    chk("s0_ff", 32'(first_fail), 32'h01);
    chk("s0_fv", 32'(fail_valid), 32'd1);
    chk("s0_pass", 32'(pass), 32'd0);
    repeat (5) @(negedge clk);
    chk("s0_err_hold", 32'(err_count), 32'd128);
    chk("s0_ff_hold", 32'(first_fail), 32'h01);

    // cout stuck at 0: every sum >= 16 fails.
    fault = 2;
    run_sweep(0, 0, dc);
    chk("co_err", 32'(err_count), 32'd120);
    chk("co_ff", 32'(first_fail), 32'h1F);
    chk("co_pass", 32'(pass), 32'd0);

    // Correct adder after a failing sweep, with a stray start at cycle 200.
    fault = 0;
    run_sweep(200, 0, dc);
    chk("restart_done_cyc", 32'(dc), 32'd513);
    chk("restart_pass", 32'(pass), 32'd1);
    chk("restart_err", 32'(err_count), 32'd0);
    chk("restart_fv", 32'(fail_valid), 32'd0);

    // Reset at cycle 300 of a failing sweep.
    fault = 1;
    run_sweep(0, 300, dc);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_results", 32'({pass, fail_valid, err_count, first_fail}), 32'd0);
    chk("mid_rst_ab", 32'({bus.dut_a, bus.dut_b}), 32'd0);
    repeat (4) @(negedge clk);
    chk("mid_rst_idle", 32'({busy, done, bus.dut_a, bus.dut_b}), 32'd0);
    fault = 0;
    run_sweep(0, 0, dc);
    chk("post_rst_done_cyc", 32'(dc), 32'd513);
    chk("post_rst_pass", 32'(pass), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
